// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access codes and FSM encoding for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane positioning and load lane extraction/extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en    = 4'b1111;
        store_word = store_data;
        case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << lane;
                store_word = {4{store_data[7:0]}};
            end
            F3_H: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lane)
            2'd0:    sel_byte = mem_word[7:0];
            2'd1:    sel_byte = mem_word[15:8];
            2'd2:    sel_byte = mem_word[23:16];
            default: sel_byte = mem_word[31:24];
        endcase
        sel_half = lane[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Unlisted load codes fall through to a full-word read.
    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder driving the pipeline BUSYWAIT
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [AW-1:0] lat_idx;
    logic [1:0]    lat_lane;
    logic [2:0]    lat_f3;
    logic [31:0]   lat_wdata;
    logic          lat_store;
    logic          access_fire;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [31:0]   load_data;
    logic          unused_addr;

    assign unused_addr = ^ADDRESS[31:AW+2];
    assign access_fire = (state == ST_BUSY) && (count == CW'(1));

    dmem_lane_align u_align (
        .funct3     (lat_f3),
        .lane       (lat_lane),
        .store_data (lat_wdata),
        .mem_word   (mem[lat_idx]),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data)
    );

    // The accept cycle stalls combinationally so the stall spans exactly LATENCY cycles.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (!RESET) begin
            case (state)
                ST_IDLE: BUSYWAIT = READ | WRITE;
                ST_BUSY: BUSYWAIT = 1'b1;
                default: BUSYWAIT = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            count     <= '0;
            READ_DATA <= 32'd0;
            lat_idx   <= '0;
            lat_lane  <= 2'd0;
            lat_f3    <= 3'd0;
            lat_wdata <= 32'd0;
            lat_store <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (READ | WRITE) begin
                        lat_idx   <= ADDRESS[AW+1:2];
                        lat_lane  <= ADDRESS[1:0];
                        lat_f3    <= FUNCT3;
                        lat_wdata <= WRITE_DATA;
                        lat_store <= WRITE;
                        count     <= CW'(LATENCY - 1);
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    count <= count - CW'(1);
                    if (access_fire) begin
                        state <= ST_ACK;
                        if (!lat_store) READ_DATA <= load_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array has no reset; a reset edge suppresses the pending write.
    always_ff @(posedge CLK) begin
        if (!RESET && access_fire && lat_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[lat_idx][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

endmodule
